dsa_uart_host: RTL

DSA_UART_HOST -- requirements
Module: dsa_uart_host

---
 rtl/dsa_uart_pkg.sv | 48 ++++
 rtl/dsa_uart_host.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/dsa_uart_pkg.sv
// Shared command codes, handshake bytes, status and state encodings for the DSA UART link.
// Used by the host-side dsa_uart_host and by the FPGA-side responder.
package dsa_uart_pkg;

  localparam logic [7:0] CMD_CONFIG   = 8'h01;
  localparam logic [7:0] CMD_WRMEM    = 8'h02;
  localparam logic [7:0] CMD_RDMEM    = 8'h03;
  localparam logic [7:0] CMD_START    = 8'h04;
  localparam logic [7:0] CMD_STATUS   = 8'h05;
  localparam logic [7:0] CMD_COUNTERS = 8'h06;
  localparam logic [7:0] CMD_SETADDR  = 8'h07;
  localparam logic [7:0] CMD_RESET    = 8'h08;

  localparam logic [7:0] ACK_BYTE = 8'hAA;
  localparam logic [7:0] NAK_BYTE = 8'hFF;

  typedef enum logic [1:0] {
    STATUS_OK      = 2'b00,
    STATUS_NAK     = 2'b01,
    STATUS_PROTO   = 2'b10,
    STATUS_TIMEOUT = 2'b11
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_SYNC,
    S_SEND_CMD,
    S_SEND_PL,
    S_WAIT_ACK,
    S_RECV_DATA,
    S_DONE
  } state_e;

  function automatic logic cmd_known(input logic [7:0] cmd);
    return (cmd >= CMD_CONFIG) && (cmd <= CMD_RESET);
  endfunction

  // Commands followed by a 4-byte payload on tx.
  function automatic logic cmd_has_payload(input logic [7:0] cmd);
    return (cmd == CMD_CONFIG) || (cmd == CMD_WRMEM) || (cmd == CMD_SETADDR);
  endfunction

  // Commands whose ACK is followed by a 4-byte data word on rx.
  function automatic logic cmd_has_data(input logic [7:0] cmd);
    return (cmd == CMD_RDMEM) || (cmd == CMD_STATUS) || (cmd == CMD_COUNTERS);
  endfunction

endpackage

// File: rtl/dsa_uart_host.sv
// Host-side command engine: frames SYNC+CMD(+payload) onto tx, then collects ACK/NAK and data from rx.
// Optional rx inactivity timeout is compiled in with DSA_UART_HOST_TIMEOUT_EN.
module dsa_uart_host
  import dsa_uart_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = 8'h55,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_cmd,
  input  logic [31:0] req_payload,
  output logic        rsp_valid,
  output logic [1:0]  rsp_status,
  output logic [31:0] rsp_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        busy
);

  state_e      state_reg, state_next;
  logic [7:0]  cmd_reg;
  logic [31:0] payload_reg;
  logic [31:0] acc_reg;
  logic [1:0]  cnt_reg;
  status_e     rsp_status_reg, fin_status;
  logic [31:0] rsp_data_reg, fin_data;

`ifdef DSA_UART_HOST_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = TIMEOUT_CYCLES - 1;
  logic [31:0] tmo_reg;
  logic        rx_take;
  logic        tmo_hit;

  assign rx_take = rx_valid && (state_reg == S_WAIT_ACK || state_reg == S_RECV_DATA);
  assign tmo_hit = !rx_valid && (tmo_reg == TMO_LAST) &&
                   (state_reg == S_WAIT_ACK || state_reg == S_RECV_DATA);
`endif

  assign req_ready  = (state_reg == S_IDLE);
  assign busy       = (state_reg != S_IDLE);
  assign rsp_valid  = (state_reg == S_DONE);
  assign rsp_status = rsp_status_reg;
  assign rsp_data   = rsp_data_reg;

  always_comb begin
    state_next = state_reg;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    fin_status = STATUS_OK;
    fin_data   = 32'h0;
    case (state_reg)
      S_IDLE: begin
        if (req_valid) begin
          if (cmd_known(req_cmd)) begin
            state_next = S_SEND_SYNC;
          end else begin
            state_next = S_DONE;
            fin_status = STATUS_PROTO;
          end
        end
      end
      S_SEND_SYNC: begin
        tx_valid = 1'b1;
        tx_data  = SYNC_BYTE;
        if (tx_ready) state_next = S_SEND_CMD;
      end
      S_SEND_CMD: begin
        tx_valid = 1'b1;
        tx_data  = cmd_reg;
        if (tx_ready) state_next = cmd_has_payload(cmd_reg) ? S_SEND_PL : S_WAIT_ACK;
      end
      S_SEND_PL: begin
        tx_valid = 1'b1;
        tx_data  = payload_reg[{cnt_reg, 3'b000} +: 8];
        if (tx_ready && cnt_reg == 2'd3) state_next = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (rx_valid) begin
          if (rx_data == ACK_BYTE) begin
            state_next = cmd_has_data(cmd_reg) ? S_RECV_DATA : S_DONE;
          end else if (rx_data == NAK_BYTE) begin
            state_next = S_DONE;
            fin_status = STATUS_NAK;
          end else begin
            state_next = S_DONE;
            fin_status = STATUS_PROTO;
          end
        end
      end
      S_RECV_DATA: begin
        if (rx_valid && cnt_reg == 2'd3) begin
          state_next = S_DONE;
          fin_data   = {rx_data, acc_reg[23:0]};
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
`ifdef DSA_UART_HOST_TIMEOUT_EN
    if (tmo_hit) begin
      state_next = S_DONE;
      fin_status = STATUS_TIMEOUT;
      fin_data   = acc_reg;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      cmd_reg        <= 8'h00;
      payload_reg    <= 32'h0;
      acc_reg        <= 32'h0;
      cnt_reg        <= 2'd0;
      rsp_status_reg <= STATUS_OK;
      rsp_data_reg   <= 32'h0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_IDLE && req_valid) begin
        cmd_reg     <= req_cmd;
        payload_reg <= req_payload;
        acc_reg     <= 32'h0;
      end
      // Byte counter is shared by the payload and data phases and restarts on every state change.
      if (state_next != state_reg) begin
        cnt_reg <= 2'd0;
      end else if ((state_reg == S_SEND_PL && tx_ready) ||
                   (state_reg == S_RECV_DATA && rx_valid)) begin
        cnt_reg <= cnt_reg + 2'd1;
      end
      if (state_reg == S_RECV_DATA && rx_valid) begin
        acc_reg[{cnt_reg, 3'b000} +: 8] <= rx_data;
      end
      if (state_next == S_DONE && state_reg != S_DONE) begin
        rsp_status_reg <= fin_status;
        rsp_data_reg   <= fin_data;
      end
    end
  end

`ifdef DSA_UART_HOST_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_reg <= 32'h0;
    end else if (state_next != state_reg || rx_take) begin
      tmo_reg <= 32'h0;
    end else begin
      tmo_reg <= tmo_reg + 32'h1;
    end
  end
`endif

endmodule
